// File: rtl/pcie_dma_pkg.sv
// Shared types for the PCIe PIO/DMA memory path.
// Request bundle and arbiter state encoding.
package pcie_dma_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic        write;
    logic [9:0]  bytes;
    logic [12:0] addr;
    logic [7:0]  strob;
    logic [63:0] data;
    logic        last;
  } mem_req_t;

  localparam int unsigned CNT_W = 10;

endpackage

// File: rtl/pcie_io_mem_arbiter.sv
// Two-port round-robin arbiter in front of a shared memory target.
// Burst lock on last=0, response timeout with error data.
module pcie_io_mem_arbiter
  import pcie_dma_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter logic [63:0] ERR_DATA = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic        i_req0_write,
  input  logic [9:0]  i_req0_bytes,
  input  logic [12:0] i_req0_addr,
  input  logic [7:0]  i_req0_strob,
  input  logic [63:0] i_req0_data,
  input  logic        i_req0_last,
  output logic        o_resp0_valid,
  output logic [63:0] o_resp0_data,
  output logic        o_resp0_err,
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic        i_req1_write,
  input  logic [9:0]  i_req1_bytes,
  input  logic [12:0] i_req1_addr,
  input  logic [7:0]  i_req1_strob,
  input  logic [63:0] i_req1_data,
  input  logic        i_req1_last,
  output logic        o_resp1_valid,
  output logic [63:0] o_resp1_data,
  output logic        o_resp1_err,
  output logic        o_mem_valid,
  input  logic        i_mem_ready,
  output logic        o_mem_write,
  output logic [9:0]  o_mem_bytes,
  output logic [12:0] o_mem_addr,
  output logic [7:0]  o_mem_strob,
  output logic [63:0] o_mem_data,
  output logic        o_mem_last,
  input  logic        i_mem_resp_valid,
  input  logic [63:0] i_mem_resp_data
);

  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t       state_q, state_d;
  mem_req_t         req_q, req_d;
  mem_req_t         req0, req1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prio_q, prio_d;
  logic             lock_q, lock_d;
  logic             lock_port_q, lock_port_d;
  logic             own_q, own_d;
  logic [1:0]       ready_q, ready_d;
  logic             mem_valid_q, mem_valid_d;
  logic [1:0]       resp_valid_q, resp_valid_d;
  logic [63:0]      resp_data_q, resp_data_d;
  logic             resp_err_q, resp_err_d;
  logic [1:0]       elig;
  logic             win;
  logic             done;
  logic             tmo;

  assign req0 = '{i_req0_write, i_req0_bytes,
                  i_req0_addr, i_req0_strob,
                  i_req0_data, i_req0_last};
  assign req1 = '{i_req1_write, i_req1_bytes,
                  i_req1_addr, i_req1_strob,
                  i_req1_data, i_req1_last};

  // A locked burst only lets its own port back in.
  always_comb begin
    elig[0] = i_req0_valid
            & (~lock_q | (lock_port_q == 1'b0));
    elig[1] = i_req1_valid
            & (~lock_q | (lock_port_q == 1'b1));
    win = (&elig) ? prio_q : elig[1];
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    cnt_d        = cnt_q;
    prio_d       = prio_q;
    lock_d       = lock_q;
    lock_port_d  = lock_port_q;
    own_d        = own_q;
    ready_d      = 2'b00;
    mem_valid_d  = mem_valid_q;
    resp_valid_d = 2'b00;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    done         = 1'b0;
    tmo          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|elig) begin
          own_d        = win;
          req_d        = win ? req1 : req0;
          ready_d[win] = 1'b1;
          mem_valid_d  = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (i_mem_ready) begin
          mem_valid_d = 1'b0;
          cnt_d       = '0;
          if (i_mem_resp_valid) begin
            done = 1'b1;
          end else begin
            state_d = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        cnt_d = cnt_q + 1'b1;
        if (i_mem_resp_valid) begin
          done = 1'b1;
        end else if (cnt_q == TMO_LAST) begin
          done = 1'b1;
          tmo  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (done) begin
      state_d             = IDLE;
      resp_valid_d[own_q] = 1'b1;
      resp_err_d          = tmo;
      resp_data_d         = tmo ? ERR_DATA
                                : i_mem_resp_data;
      if (req_q.last) begin
        lock_d = 1'b0;
        prio_d = ~own_q;
      end else begin
        lock_d      = 1'b1;
        lock_port_d = own_q;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q      <= IDLE;
      req_q        <= '0;
      cnt_q        <= '0;
      prio_q       <= 1'b0;
      lock_q       <= 1'b0;
      lock_port_q  <= 1'b0;
      own_q        <= 1'b0;
      ready_q      <= 2'b00;
      mem_valid_q  <= 1'b0;
      resp_valid_q <= 2'b00;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      cnt_q        <= cnt_d;
      prio_q       <= prio_d;
      lock_q       <= lock_d;
      lock_port_q  <= lock_port_d;
      own_q        <= own_d;
      ready_q      <= ready_d;
      mem_valid_q  <= mem_valid_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign o_req0_ready  = ready_q[0];
  assign o_req1_ready  = ready_q[1];
  assign o_mem_valid   = mem_valid_q;
  assign o_mem_write   = req_q.write;
  assign o_mem_bytes   = req_q.bytes;
  assign o_mem_addr    = req_q.addr;
  assign o_mem_strob   = req_q.strob;
  assign o_mem_data    = req_q.data;
  assign o_mem_last    = req_q.last;
  assign o_resp0_valid = resp_valid_q[0];
  assign o_resp1_valid = resp_valid_q[1];
  assign o_resp0_data  = resp_valid_q[0] ? resp_data_q : '0;
  assign o_resp1_data  = resp_valid_q[1] ? resp_data_q : '0;
  assign o_resp0_err   = resp_valid_q[0] & resp_err_q;
  assign o_resp1_err   = resp_valid_q[1] & resp_err_q;

endmodule

// File: doc/pcie_io_mem_arbiter.md
PCIE_IO_MEM_ARBITER -- requirements
Module: pcie_io_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023: cycles to wait for a target response before an error response is forced.
REQ-002 SHALL have parameter ERR_DATA, default 64'hFFFF_FFFF_FFFF_FFFF: read data returned on timeout.
REQ-003 SHALL have port i_clk, in, 1: the single clock, all logic on the rising edge.
REQ-004 SHALL have port i_nrst, in, 1: reset, asynchronous, active-low.
REQ-005 SHALL have ports i_reqN_valid, in, 1, for N=0 (PIO RX engine) and N=1 (DMA engine): request valid.
REQ-006 SHALL have ports o_reqN_ready, out, 1: one-cycle capture acknowledge.
REQ-007 SHALL have ports i_reqN_write, in, 1; i_reqN_bytes, in, 10; i_reqN_addr, in, 13; i_reqN_strob, in, 8; i_reqN_data, in, 64; i_reqN_last, in, 1: request fields, same encoding as the PIO memory request bus.
REQ-008 SHALL have ports o_respN_valid, out, 1; o_respN_data, out, 64; o_respN_err, out, 1: response returned to requester N.
REQ-009 SHALL have ports o_mem_valid, out, 1; i_mem_ready, in, 1; o_mem_write, out, 1; o_mem_bytes, out, 10; o_mem_addr, out, 13; o_mem_strob, out, 8; o_mem_data, out, 64; o_mem_last, out, 1: request to the shared target.
REQ-010 SHALL have ports i_mem_resp_valid, in, 1; i_mem_resp_data, in, 64: target response, one per request.

Function
REQ-011 SHALL implement states IDLE, ISSUE, WAIT_RESP, all outputs registered.
REQ-012 In IDLE, if any i_reqN_valid is set, SHALL select a winner, capture its fields, assert o_reqN_ready for exactly that cycle+1, and move to ISSUE with o_mem_valid=1 on the next cycle.
REQ-013 Arbitration SHALL be round-robin: on simultaneous requests the port not served most recently wins; after reset port 0 has priority.
REQ-014 A sole requester SHALL be granted regardless of the priority pointer.
REQ-015 In ISSUE, o_mem_valid and all o_mem_* fields SHALL hold stable until i_mem_ready=1; then o_mem_valid clears next cycle and state goes to WAIT_RESP.
REQ-016 If i_mem_resp_valid arrives in the same cycle as i_mem_ready, SHALL complete directly to response delivery (no lost response).
REQ-017 On i_mem_resp_valid, SHALL assert o_respN_valid for one cycle to the granted port only, with o_respN_data=i_mem_resp_data, o_respN_err=0.
REQ-018 A 10-bit cycle counter SHALL start at 0 on entering WAIT_RESP and increment each cycle; on reaching TIMEOUT_CYCLES, SHALL deliver o_respN_valid=1, o_respN_err=1, o_respN_data=ERR_DATA and leave WAIT_RESP.
REQ-019 A late i_mem_resp_valid following a timeout SHALL be discarded.
REQ-020 After response delivery, if the captured last=0, SHALL stay locked to the same port (return to IDLE considering only that port); if last=1, SHALL update the priority pointer and release.
REQ-021 Ungranted ports SHALL see o_reqN_ready=0 and o_respN_valid=0 at all times.

Reset
REQ-022 On i_nrst=0, state SHALL be IDLE, pointer=port 0, lock clear, counter 0, and every output 0, taking effect immediately.
REQ-023 Reset mid-transaction SHALL drop the in-flight request silently; no response SHALL be generated afterward.

Structure
REQ-024 State encoding and a request-field struct (write, bytes, addr, strob, data, last) SHALL reside in shared package pcie_dma_pkg.
REQ-025 Single module, no sub-modules; a combinational block computes next-state and a register block with async reset.

Verification
REQ-026 Only req0 valid, write addr 13'h0104 data 64'h1122334455667788, ready=1, resp 3 cycles later -> o_mem_valid 1 cycle after capture, o_resp0_valid once, o_resp1_valid never.
REQ-027 req0 and req1 valid together twice in a row -> grants port 0 then port 1.
REQ-028 i_mem_ready held low 5 cycles -> o_mem_addr/data stable for all 5 cycles, valid drops the cycle after ready.
REQ-029 No response, TIMEOUT_CYCLES=16 -> o_respN_err=1, data all-ones 16 cycles after WAIT_RESP entry; later resp ignored.
REQ-030 req1 with last=0 then last=1 while req0 pending -> port 1 holds both beats, then port 0 granted.
REQ-031 i_nrst pulsed low in WAIT_RESP -> all outputs 0 immediately, no response issued after release.
